// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: collects words of one frame, validates the frame on
// end-of-frame (error, FCS and length checks), then presents it for reading
// word by word. A new frame start overwrites any frame still held.
module rx_frame_buffer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 128,
  parameter int FCS_BYTES = 2,
  parameter int SIZE_W    = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Rx_ValidFrame,
  input  logic              Rx_WrBuff,
  input  logic [DATA_W-1:0] Rx_Data,
  input  logic              Rx_EoF,
  input  logic              Rx_AbortDetect,
  input  logic              Rx_FrameError,
  input  logic              Rx_FCSen,
  input  logic              Rx_FCSerr,
  input  logic              Rx_RdBuff,
  input  logic              Rx_Drop,
  output logic [DATA_W-1:0] Rx_DataBuffOut,
  output logic              Rx_Ready,
  output logic [SIZE_W-1:0] Rx_FrameSize,
  output logic              Rx_Overflow,
  output logic              Rx_AbortSignal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q;
  logic [SIZE_W-1:0] cnt_q;
  logic [SIZE_W-1:0] rd_idx_q;
  logic [SIZE_W-1:0] size_q;
  logic              ready_q;
  logic              ovf_q;
  logic              abort_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_valid;
  logic              frame_start;
  logic              store;
  logic              ovf_hit;
  logic [AW-1:0]     store_idx;
  logic [SIZE_W-1:0] cnt_d;
  logic [SIZE_W-1:0] size_d;
  logic              ovf_d;
  logic              bad_frame;
  logic              holding;
  logic              rd_ok;
  logic              rd_last;

  // Write qualification, next count/overflow and end-of-frame verdict.
  always_comb begin
    wr_valid    = Rx_WrBuff & Rx_ValidFrame;
    frame_start = wr_valid & (state_q != FILL);
    store       = 1'b0;
    ovf_hit     = 1'b0;
    store_idx   = '0;
    cnt_d       = cnt_q;
    if (frame_start) begin
      // A new frame always lands at index 0, whatever was held before.
      store = 1'b1;
      cnt_d = {{(SIZE_W-1){1'b0}}, 1'b1};
    end else if ((state_q == FILL) && wr_valid && !Rx_AbortDetect) begin
      if (cnt_q < SIZE_W'(DEPTH)) begin
        store     = 1'b1;
        store_idx = cnt_q[AW-1:0];
        cnt_d     = cnt_q + {{(SIZE_W-1){1'b0}}, 1'b1};
      end else begin
        ovf_hit = 1'b1;
      end
    end else begin
      store = 1'b0;
    end
    ovf_d     = frame_start ? 1'b0 : (ovf_q | ovf_hit);
    // The word written alongside EoF is already counted in cnt_d.
    bad_frame = Rx_FrameError | (Rx_FCSen & Rx_FCSerr) |
                (Rx_FCSen & (cnt_d <= SIZE_W'(FCS_BYTES)));
    if (Rx_FCSen && !ovf_d) begin
      size_d = cnt_d - SIZE_W'(FCS_BYTES);
    end else begin
      size_d = cnt_d;
    end
    holding = (state_q == READY) || (state_q == DRAIN);
    rd_ok   = rd_idx_q < size_q;
    rd_last = rd_idx_q == (size_q - {{(SIZE_W-1){1'b0}}, 1'b1});
  end

  // Frame storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge Clk) begin
    if (store) begin
      mem_q[store_idx] <= Rx_Data;
    end
  end

  // Frame state machine with all status outputs registered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_idx_q <= '0;
      size_q   <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      abort_q  <= 1'b0;
      dout_q   <= '0;
    end else begin
      abort_q <= 1'b0;
      if (frame_start) begin
        // Covers IDLE and overwriting a frame still held in READY/DRAIN.
        state_q  <= FILL;
        cnt_q    <= cnt_d;
        rd_idx_q <= '0;
        size_q   <= '0;
        ready_q  <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            // Past the end of any drained frame: reads yield zero.
            if (Rx_RdBuff) begin
              dout_q <= '0;
            end
          end
          FILL: begin
            if (Rx_AbortDetect) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              abort_q <= 1'b1;
            end else if (Rx_EoF) begin
              ovf_q <= ovf_d;
              if (bad_frame) begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                state_q  <= READY;
                cnt_q    <= cnt_d;
                size_q   <= size_d;
                rd_idx_q <= '0;
                ready_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
          end
          READY, DRAIN: begin
            if (Rx_Drop) begin
              state_q  <= IDLE;
              cnt_q    <= '0;
              rd_idx_q <= '0;
              ready_q  <= 1'b0;
            end else if (Rx_RdBuff && holding) begin
              if (rd_ok) begin
                dout_q   <= mem_q[rd_idx_q[AW-1:0]];
                rd_idx_q <= rd_idx_q + {{(SIZE_W-1){1'b0}}, 1'b1};
                if (rd_last) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                end else begin
                  state_q <= DRAIN;
                end
              end else begin
                dout_q <= '0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Rx_DataBuffOut = dout_q;
  assign Rx_Ready       = ready_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_AbortSignal = abort_q;

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: normal, overflow, abort, discard,
// drop/overwrite and reset-mid-read scenarios with hand-computed results.
module tb_rx_frame_buffer;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx_ValidFrame = 1'b0;
  logic       Rx_WrBuff = 1'b0;
  logic [7:0] Rx_Data = 8'h00;
  logic       Rx_EoF = 1'b0;
  logic       Rx_AbortDetect = 1'b0;
  logic       Rx_FrameError = 1'b0;
  logic       Rx_FCSen = 1'b0;
  logic       Rx_FCSerr = 1'b0;
  logic       Rx_RdBuff = 1'b0;
  logic       Rx_Drop = 1'b0;
  logic [7:0] Rx_DataBuffOut;
  logic       Rx_Ready;
  logic [7:0] Rx_FrameSize;
  logic       Rx_Overflow;
  logic       Rx_AbortSignal;

  int pass_cnt = 0;
  int total_cnt = 0;

  rx_frame_buffer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_WrBuff      (Rx_WrBuff),
    .Rx_Data        (Rx_Data),
    .Rx_EoF         (Rx_EoF),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_FrameError  (Rx_FrameError),
    .Rx_FCSen       (Rx_FCSen),
    .Rx_FCSerr      (Rx_FCSerr),
    .Rx_RdBuff      (Rx_RdBuff),
    .Rx_Drop        (Rx_Drop),
    .Rx_DataBuffOut (Rx_DataBuffOut),
    .Rx_Ready       (Rx_Ready),
    .Rx_FrameSize   (Rx_FrameSize),
    .Rx_Overflow    (Rx_Overflow),
    .Rx_AbortSignal (Rx_AbortSignal)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [7:0] d);
    Rx_ValidFrame = 1'b1;
    Rx_WrBuff     = 1'b1;
    Rx_Data       = d;
    @(negedge Clk);
    Rx_WrBuff     = 1'b0;
  endtask

  task automatic wr_eof(input logic [7:0] d, input logic fcsen);
    Rx_ValidFrame = 1'b1;
    Rx_WrBuff     = 1'b1;
    Rx_Data       = d;
    Rx_EoF        = 1'b1;
    Rx_FCSen      = fcsen;
    @(negedge Clk);
    Rx_WrBuff     = 1'b0;
    Rx_EoF        = 1'b0;
    Rx_ValidFrame = 1'b0;
  endtask

  task automatic eof(input logic fcsen, input logic fcserr, input logic ferr);
    Rx_EoF        = 1'b1;
    Rx_FCSen      = fcsen;
    Rx_FCSerr     = fcserr;
    Rx_FrameError = ferr;
    @(negedge Clk);
    Rx_EoF        = 1'b0;
    Rx_FCSerr     = 1'b0;
    Rx_FrameError = 1'b0;
    Rx_ValidFrame = 1'b0;
  endtask

  task automatic rd();
    Rx_RdBuff = 1'b1;
    @(negedge Clk);
    Rx_RdBuff = 1'b0;
  endtask

  task automatic drop();
    Rx_Drop = 1'b1;
    @(negedge Clk);
    Rx_Drop = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_ready", 32'(Rx_Ready), 32'h0);
    chk("rst_size", 32'(Rx_FrameSize), 32'h0);
    chk("rst_ovf", 32'(Rx_Overflow), 32'h0);
    chk("rst_abort", 32'(Rx_AbortSignal), 32'h0);
    chk("rst_dout", 32'(Rx_DataBuffOut), 32'h0);
    Rst = 1'b0;
    @(negedge Clk);

    // Normal frame with FCS stripping: 6 words -> 4 readable
    for (int i = 0; i < 6; i++) wr(8'(8'h11 + i));
    eof(1'b1, 1'b0, 1'b0);
    chk("norm_ready", 32'(Rx_Ready), 32'h1);
    chk("norm_size", 32'(Rx_FrameSize), 32'h4);
    chk("norm_ovf", 32'(Rx_Overflow), 32'h0);
    rd();
    chk("norm_rd0", 32'(Rx_DataBuffOut), 32'h11);
    rd();
    chk("norm_rd1", 32'(Rx_DataBuffOut), 32'h12);
    @(negedge Clk);
    chk("norm_hold", 32'(Rx_DataBuffOut), 32'h12);
    rd();
    chk("norm_rd2", 32'(Rx_DataBuffOut), 32'h13);
    chk("norm_ready_mid", 32'(Rx_Ready), 32'h1);
    rd();
    chk("norm_rd3", 32'(Rx_DataBuffOut), 32'h14);
    chk("norm_ready_end", 32'(Rx_Ready), 32'h0);
    rd();
    chk("norm_rd_past", 32'(Rx_DataBuffOut), 32'h0);

    // Overflow: 130 words into 128, FCS stripping suppressed
    for (int i = 0; i < 128; i++) wr(8'(i + 1));
    chk("ovf_at_full", 32'(Rx_Overflow), 32'h0);
    wr(8'hAA);
    chk("ovf_set", 32'(Rx_Overflow), 32'h1);
    wr(8'hBB);
    eof(1'b1, 1'b0, 1'b0);
    chk("ovf_ready", 32'(Rx_Ready), 32'h1);
    chk("ovf_size", 32'(Rx_FrameSize), 32'd128);
    chk("ovf_flag", 32'(Rx_Overflow), 32'h1);
    rd();
    chk("ovf_rd0", 32'(Rx_DataBuffOut), 32'h01);
    drop();
    chk("ovf_drop_ready", 32'(Rx_Ready), 32'h0);
    chk("ovf_sticky", 32'(Rx_Overflow), 32'h1);

    // Abort mid-frame, then a plain 5-word frame
    wr(8'hE1);
    chk("abort_ovf_clr", 32'(Rx_Overflow), 32'h0);
    wr(8'hE2);
    wr(8'hE3);
    Rx_AbortDetect = 1'b1;
    @(negedge Clk);
    Rx_AbortDetect = 1'b0;
    Rx_ValidFrame  = 1'b0;
    chk("abort_pulse", 32'(Rx_AbortSignal), 32'h1);
    chk("abort_ready", 32'(Rx_Ready), 32'h0);
    @(negedge Clk);
    chk("abort_pulse_end", 32'(Rx_AbortSignal), 32'h0);
    for (int i = 0; i < 5; i++) wr(8'(8'h21 + i));
    eof(1'b0, 1'b0, 1'b0);
    chk("post_abort_ready", 32'(Rx_Ready), 32'h1);
    chk("post_abort_size", 32'(Rx_FrameSize), 32'h5);
    rd();
    chk("post_abort_rd0", 32'(Rx_DataBuffOut), 32'h21);

    // Drop wins over a simultaneous read
    Rx_Drop   = 1'b1;
    Rx_RdBuff = 1'b1;
    @(negedge Clk);
    Rx_Drop   = 1'b0;
    Rx_RdBuff = 1'b0;
    chk("drop_ready", 32'(Rx_Ready), 32'h0);
    chk("drop_dout", 32'(Rx_DataBuffOut), 32'h21);
    Rx_AbortDetect = 1'b1;
    @(negedge Clk);
    Rx_AbortDetect = 1'b0;
    @(negedge Clk);
    chk("idle_abort_none", 32'(Rx_AbortSignal), 32'h0);

    // Overwrite a held frame; invalid write inside the new frame is ignored
    wr(8'h31);
    wr(8'h32);
    eof(1'b0, 1'b0, 1'b0);
    chk("ow_first_ready", 32'(Rx_Ready), 32'h1);
    chk("ow_first_size", 32'(Rx_FrameSize), 32'h2);
    wr(8'h41);
    chk("ow_ready_clr", 32'(Rx_Ready), 32'h0);
    wr(8'h42);
    Rx_ValidFrame = 1'b0;
    Rx_WrBuff     = 1'b1;
    Rx_Data       = 8'h99;
    @(negedge Clk);
    Rx_WrBuff     = 1'b0;
    wr(8'h43);
    eof(1'b0, 1'b0, 1'b0);
    chk("ow_ready", 32'(Rx_Ready), 32'h1);
    chk("ow_size", 32'(Rx_FrameSize), 32'h3);
    rd();
    chk("ow_rd0", 32'(Rx_DataBuffOut), 32'h41);
    rd();
    chk("ow_rd1", 32'(Rx_DataBuffOut), 32'h42);
    rd();
    chk("ow_rd2", 32'(Rx_DataBuffOut), 32'h43);
    chk("ow_ready_end", 32'(Rx_Ready), 32'h0);

    // Discards: FCS error, too short for FCS, framing error
    for (int i = 0; i < 4; i++) wr(8'(8'h51 + i));
    eof(1'b1, 1'b1, 1'b0);
    chk("fcserr_ready", 32'(Rx_Ready), 32'h0);
    wr(8'h61);
    wr(8'h62);
    eof(1'b1, 1'b0, 1'b0);
    chk("short_ready", 32'(Rx_Ready), 32'h0);
    for (int i = 0; i < 4; i++) wr(8'(8'h71 + i));
    eof(1'b0, 1'b0, 1'b1);
    chk("ferr_ready", 32'(Rx_Ready), 32'h0);
    // Shortest frame that survives FCS stripping: 3 words -> 1
    wr(8'h81);
    wr(8'h82);
    wr(8'h83);
    eof(1'b1, 1'b0, 1'b0);
    chk("min_ready", 32'(Rx_Ready), 32'h1);
    chk("min_size", 32'(Rx_FrameSize), 32'h1);
    rd();
    chk("min_rd0", 32'(Rx_DataBuffOut), 32'h81);
    chk("min_ready_end", 32'(Rx_Ready), 32'h0);

    // Reset in the middle of reading, then recover
    wr(8'h91);
    wr(8'h92);
    wr(8'h93);
    wr_eof(8'h94, 1'b0);
    chk("rr_size", 32'(Rx_FrameSize), 32'h4);
    rd();
    chk("rr_rd0", 32'(Rx_DataBuffOut), 32'h91);
    rd();
    chk("rr_rd1", 32'(Rx_DataBuffOut), 32'h92);
    Rst = 1'b1;
    #1;
    chk("rr_rst_ready", 32'(Rx_Ready), 32'h0);
    chk("rr_rst_size", 32'(Rx_FrameSize), 32'h0);
    chk("rr_rst_dout", 32'(Rx_DataBuffOut), 32'h0);
    chk("rr_rst_ovf", 32'(Rx_Overflow), 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    wr(8'hA1);
    wr(8'hA2);
    wr_eof(8'hA3, 1'b0);
    chk("rr_new_ready", 32'(Rx_Ready), 32'h1);
    chk("rr_new_size", 32'(Rx_FrameSize), 32'h3);
    rd();
    chk("rr_new_rd0", 32'(Rx_DataBuffOut), 32'hA1);
    rd();
    chk("rr_new_rd1", 32'(Rx_DataBuffOut), 32'hA2);
    rd();
    chk("rr_new_rd2", 32'(Rx_DataBuffOut), 32'hA3);
    chk("rr_new_ready_end", 32'(Rx_Ready), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rx_frame_buffer.md
RX_FRAME_BUFFER -- requirements
Module: rx_frame_buffer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide the following parameters, one per line (name, default, meaning):
- DATA_W, 8: received word width in bits.
- DEPTH, 128: buffer capacity in words, minimum 4.
- FCS_BYTES, 2: FCS words stripped from the frame size, either 2 or 4.
- SIZE_W, $clog2(DEPTH+1): width of the frame-size count (derived).
REQ-003 The block SHALL provide the following ports, one per line (name, direction, width, meaning):
- Clk, in, 1: clock.
- Rst, in, 1: asynchronous active-high reset.
- Rx_ValidFrame, in, 1: a frame is in progress.
- Rx_WrBuff, in, 1: write strobe for Rx_Data.
- Rx_Data, in, DATA_W: received word.
- Rx_EoF, in, 1: end-of-frame pulse.
- Rx_AbortDetect, in, 1: abort-sequence pulse.
- Rx_FrameError, in, 1: framing-error pulse or level.
- Rx_FCSen, in, 1: FCS stripping and length checking enabled.
- Rx_FCSerr, in, 1: FCS mismatch, sampled with Rx_EoF.
- Rx_RdBuff, in, 1: read strobe.
- Rx_Drop, in, 1: discard the held frame.
- Rx_DataBuffOut, out, DATA_W: registered read data.
- Rx_Ready, out, 1: a complete frame is held.
- Rx_FrameSize, out, SIZE_W: readable word count.
- Rx_Overflow, out, 1: the current or held frame exceeded DEPTH.
- Rx_AbortSignal, out, 1: one-cycle pulse reporting an aborted frame.

Function
REQ-004 The block SHALL implement the states IDLE, FILL, READY and DRAIN, held in a registered state machine.
REQ-005 IDLE to FILL: on the first Rx_WrBuff while Rx_ValidFrame=1, with write pointer and count cleared to 0 beforehand and Rx_Overflow cleared.
REQ-006 FILL: each Rx_WrBuff with count<DEPTH SHALL store Rx_Data at the write pointer and increment the count.
- With count==DEPTH, the word SHALL be discarded and Rx_Overflow set; Rx_Overflow is sticky until the next frame start.
REQ-007 Rx_WrBuff and Rx_EoF in the same cycle: the word SHALL be stored first, and end-of-frame evaluation SHALL include it.
REQ-008 On Rx_EoF in FILL, the frame SHALL be discarded and the block return to IDLE when any of the following holds:
- Rx_FrameError=1;
- Rx_FCSerr=1 with Rx_FCSen=1;
- Rx_FCSen=1 and count<=FCS_BYTES.
In this case Rx_Ready stays 0.
REQ-009 Otherwise, on Rx_EoF in FILL, the block SHALL go to READY one cycle after Rx_EoF and set Rx_Ready=1.
- Rx_FrameSize SHALL be count-FCS_BYTES when Rx_FCSen=1 and Rx_Overflow=0.
- Rx_FrameSize SHALL be count in all other cases, including overflowed frames.
REQ-010 Rx_AbortDetect in FILL SHALL discard the frame, go to IDLE, and pulse Rx_AbortSignal for exactly one cycle on the next cycle.
REQ-011 Rx_AbortDetect in IDLE, READY or DRAIN SHALL have no effect.
REQ-012 READY or DRAIN, Rx_RdBuff: when the read index is below Rx_FrameSize, Rx_DataBuffOut SHALL present the word at the read index on the cycle after the strobe, and the read index SHALL increment. READY goes to DRAIN on the first read.
REQ-013 Reading the last word (index Rx_FrameSize-1) SHALL clear Rx_Ready and go to IDLE one cycle after the strobe.
- Reads with index>=Rx_FrameSize SHALL drive 0 and SHALL NOT move the index.
REQ-014 Rx_DataBuffOut SHALL hold its last value when no read strobe is active.
REQ-015 Rx_Drop in READY or DRAIN SHALL clear Rx_Ready and the pointers and go to IDLE on the next cycle. Rx_Drop takes priority over a simultaneous Rx_RdBuff.
REQ-016 A frame start (REQ-005 condition) while in READY or DRAIN SHALL discard the unread frame, clear Rx_Ready in the same cycle and enter FILL.
REQ-017 Rx_WrBuff while Rx_ValidFrame=0 SHALL be ignored in every state.
REQ-018 Rx_FrameSize SHALL hold its value from the READY transition until the next frame start or reset, and SHALL be 0 before the first completed frame.

Reset
REQ-019 Rst=1 SHALL, asynchronously and in any state (including mid-frame and mid-read), force the following:
- state IDLE;
- all pointers and the count to 0;
- Rx_Ready=0, Rx_Overflow=0, Rx_AbortSignal=0;
- Rx_FrameSize=0 and Rx_DataBuffOut=0.
Buffer contents need not be cleared.
REQ-020 After Rst deasserts, the first valid write SHALL start a new frame normally.

Verification
REQ-021 Normal frame: FCSen=1, write 0x11..0x16 (6 words), EoF -> Rx_Ready=1, Rx_FrameSize=4; four reads return 0x11,0x12,0x13,0x14, and Rx_Ready drops after the 4th read.
REQ-022 Overflow: DEPTH=128, write 130 words, FCSen=1, EoF -> Rx_Overflow=1, Rx_FrameSize=128, Rx_Ready=1.
REQ-023 Abort: write 3 words, pulse Rx_AbortDetect -> Rx_AbortSignal high for exactly 1 cycle, Rx_Ready stays 0; a following 5-word frame with FCSen=0 gives Rx_FrameSize=5.
REQ-024 Error discard and short frame:
- EoF with FCSerr=1, FCSen=1 -> Rx_Ready=0.
- A 2-word frame with FCSen=1, FCS_BYTES=2 -> Rx_Ready=0.
REQ-025 Drop and overwrite:
- Held frame, Rx_Drop together with Rx_RdBuff -> Rx_Ready=0 next cycle, Rx_DataBuffOut unchanged.
- Held frame, new frame start -> Rx_Ready=0 immediately, and the new frame's size is reported.
REQ-026 Reset mid-read: Rst asserted after 2 of 4 reads -> all outputs 0 immediately; a subsequent 3-word frame with FCSen=0 reads back correctly from index 0.
